orb_wr_arbiter: RTL

ORB_WR_ARBITER -- requirements
Module: orb_wr_arbiter

---
 rtl/orb_wr_arbiter_pkg.sv | 15 +
 rtl/orb_wr_arbiter_rr_grant4.sv | 25 ++
 rtl/orb_wr_arbiter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/orb_wr_arbiter_pkg.sv
// Shared types and widths for the ORB frame-RAM write arbiter.
package orb_wr_arbiter_pkg;

  localparam int ADDR_W        = 11;
  localparam int WORD_W        = 12;
  localparam int BURST_DEFAULT = 16;
  localparam int CNT_W         = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/orb_wr_arbiter_rr_grant4.sv
// Four-way round-robin grant: the search starts one past the last granted index.
module rr_grant4 (
  input  logic [3:0] i_elig,
  input  logic [1:0] i_last,
  output logic [3:0] o_gnt,
  output logic [1:0] o_idx
);

  logic [1:0] w_cand;

  // Scan from farthest to nearest so the nearest eligible requester after i_last wins
  always_comb begin
    o_gnt  = '0;
    o_idx  = i_last;
    w_cand = i_last;
    for (int k = 4; k >= 1; k--) begin
      w_cand = i_last + k[1:0];
      if (i_elig[w_cand]) begin
        o_gnt = 4'b0001 << w_cand;
        o_idx = w_cand;
      end
    end
  end

endmodule

// File: rtl/orb_wr_arbiter.sv
// Arbitrates four requester FIFOs into one frame-RAM write port, moving
// BURST words per grant and writing into the bank selected by the frame timer.
module orb_wr_arbiter
  import orb_wr_arbiter_pkg::*;
#(
  parameter int BURST = BURST_DEFAULT,
  parameter int UW    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [UW-1:0]     usedw0,
  input  logic [UW-1:0]     usedw1,
  input  logic [UW-1:0]     usedw2,
  input  logic [UW-1:0]     usedw3,
  input  logic [WORD_W-1:0] data0,
  input  logic [WORD_W-1:0] data1,
  input  logic [WORD_W-1:0] data2,
  input  logic [WORD_W-1:0] data3,
  input  logic [ADDR_W-1:0] base0,
  input  logic [ADDR_W-1:0] base1,
  input  logic [ADDR_W-1:0] base2,
  input  logic [ADDR_W-1:0] base3,
  input  logic              sw,
  input  logic              clrOvf,
  output logic              rdreq0,
  output logic              rdreq1,
  output logic              rdreq2,
  output logic              rdreq3,
  output logic [ADDR_W-1:0] wAddr,
  output logic [WORD_W-1:0] wData,
  output logic              WE,
  output logic              bank,
  output logic              busy,
  output logic [3:0]        ovf
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST - 1);

  state_t              r_state;
  logic [1:0]          r_ptr;
  logic [1:0]          r_gidx;
  logic [3:0]          r_rdreq;
  logic [ADDR_W-1:0]   r_base;
  logic [CNT_W-1:0]    r_rd_cnt;
  logic                r_fl_cnt;
  logic                r_busy;
  logic                r_sw;
  logic                r_bank;
  logic [3:0]          r_ovf;
  logic                r_vld_p1;
  logic [CNT_W-1:0]    r_idx;
  logic                r_we_p2;
  logic [ADDR_W-1:0]   r_waddr_p2;
  logic [WORD_W-1:0]   r_wdata_p2;

  logic [3:0]          w_elig;
  logic [3:0]          w_full;
  logic [3:0]          w_gnt;
  logic [1:0]          w_gidx;
  logic                w_start;
  logic [ADDR_W-1:0]   w_base_sel;
  logic [WORD_W-1:0]   w_data_sel;

  assign w_elig[0] = (32'(usedw0) >= 32'(BURST));
  assign w_elig[1] = (32'(usedw1) >= 32'(BURST));
  assign w_elig[2] = (32'(usedw2) >= 32'(BURST));
  assign w_elig[3] = (32'(usedw3) >= 32'(BURST));

  assign w_full[0] = &usedw0;
  assign w_full[1] = &usedw1;
  assign w_full[2] = &usedw2;
  assign w_full[3] = &usedw3;

  rr_grant4 u_rr (
    .i_elig (w_elig),
    .i_last (r_ptr),
    .o_gnt  (w_gnt),
    .o_idx  (w_gidx)
  );

  // Eligibility only matters while idle; mid-burst arrivals wait for the next IDLE
  assign w_start = (r_state == ST_IDLE) && (|w_elig);

  // Base address of the requester about to be granted, and data of the granted one
  always_comb begin
    w_base_sel = base0;
    w_data_sel = data0;
    case (w_gidx)
      2'd1:    w_base_sel = base1;
      2'd2:    w_base_sel = base2;
      2'd3:    w_base_sel = base3;
      default: w_base_sel = base0;
    endcase
    case (r_gidx)
      2'd1:    w_data_sel = data1;
      2'd2:    w_data_sel = data2;
      2'd3:    w_data_sel = data3;
      default: w_data_sel = data0;
    endcase
  end

  // Burst control FSM: grant, BURST read strobes, two-cycle drain, bank switch at idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_ptr    <= 2'd3;
      r_gidx   <= 2'd0;
      r_rdreq  <= '0;
      r_base   <= '0;
      r_rd_cnt <= '0;
      r_fl_cnt <= 1'b0;
      r_busy   <= 1'b0;
      r_sw     <= 1'b0;
      r_bank   <= 1'b0;
    end else begin
      r_sw <= sw;
      case (r_state)
        ST_IDLE: begin
          r_bank <= r_sw;
          if (w_start) begin
            r_state  <= ST_READ;
            r_rdreq  <= w_gnt;
            r_gidx   <= w_gidx;
            r_ptr    <= w_gidx;
            r_base   <= w_base_sel;
            r_rd_cnt <= '0;
            r_busy   <= 1'b1;
          end
        end
        ST_READ: begin
          if (r_rd_cnt == CNT_LAST) begin
            r_rdreq  <= '0;
            r_state  <= ST_FLUSH;
            r_fl_cnt <= 1'b0;
          end else begin
            r_rd_cnt <= r_rd_cnt + 1'b1;
          end
        end
        ST_FLUSH: begin
          if (r_fl_cnt) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_bank  <= r_sw;
          end else begin
            r_fl_cnt <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_rdreq <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Write pipeline: rdreq cycle -> FIFO q valid (p1) -> registered RAM write (p2)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_p1   <= 1'b0;
      r_idx      <= '0;
      r_we_p2    <= 1'b0;
      r_waddr_p2 <= '0;
      r_wdata_p2 <= '0;
    end else begin
      r_vld_p1 <= |r_rdreq;
      // ---- p1 -> p2: FIFO word is valid now, register it with its address
      r_we_p2  <= r_vld_p1;
      if (r_vld_p1) begin
        r_waddr_p2 <= r_base + {{(ADDR_W-CNT_W){1'b0}}, r_idx};
        r_wdata_p2 <= w_data_sel;
      end
      if (w_start) begin
        r_idx <= '0;
      end else if (r_vld_p1) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  // Sticky overflow flags; a set in the same cycle as a clear takes priority
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf <= '0;
    end else begin
      r_ovf <= w_full | (r_ovf & {4{~clrOvf}});
    end
  end

  assign rdreq0 = r_rdreq[0];
  assign rdreq1 = r_rdreq[1];
  assign rdreq2 = r_rdreq[2];
  assign rdreq3 = r_rdreq[3];
  assign wAddr  = r_waddr_p2;
  assign wData  = r_wdata_p2;
  assign WE     = r_we_p2;
  assign bank   = r_bank;
  assign busy   = r_busy;
  assign ovf    = r_ovf;

endmodule
